// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - UART byte stream and BRAM port A bundle for the boot loader
//
// Signals
//   rx_data   [7:0]  received byte (environment -> loader)
//   rx_valid         rx_data valid (environment -> loader)
//   rx_ready         byte accepted when rx_valid && rx_ready (loader -> environment)
//   mem_we    [3:0]  BRAM port A byte write enables, 4'hF or 4'h0 (loader -> BRAM)
//   mem_addr  [31:0] BRAM port A byte address (loader -> BRAM)
//   mem_din   [31:0] BRAM port A write data (loader -> BRAM)
// Modports
//   master : the loader, which drives rx_ready and the BRAM write port
//   slave  : the UART/BRAM side of the connection
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_din
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing framed UART images into instruction BRAM
//
// Frame: 8'hA5, LEN (4 bytes LE, words), LEN*4 payload bytes (LE per word),
// CSUM (1 byte, XOR of payload bytes). The CPU is held in reset until a
// frame with a matching checksum has been written.
//
// Ports
//   clk_i        in   clock, all logic on posedge
//   rst_i        in   synchronous active-high reset
//   bus          if   imem_loader_if.master: rx byte stream in, BRAM port A out
//   cpu_rst_n_o  out  0 = CPU held in reset, 1 = CPU running
//   done_o       out  image loaded and verified
//   err_o        out  sticky load error (cleared by the next 8'hA5)
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic          clk_i,
    input  logic          rst_i,
    imem_loader_if.master bus,
    output logic          cpu_rst_n_o,
    output logic          done_o,
    output logic          err_o
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;       // byte lane within LEN or current word
    logic [31:0] len_q, len_d;
    logic [31:0] idx_q, idx_d;       // word index of the next write
    logic [31:0] word_q, word_d;
    logic [7:0]  csum_q, csum_d;
    logic        rx_ready_q, rx_ready_d;
    logic [3:0]  mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_din_q, mem_din_d;
    logic        run_q, run_d;
    logic        err_q, err_d;
    logic        hs;
    logic        sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            len_q      <= 32'd0;
            idx_q      <= 32'd0;
            word_q     <= 32'd0;
            csum_q     <= 8'd0;
            rx_ready_q <= 1'b1;
            mem_we_q   <= 4'h0;
            mem_addr_q <= BASE_ADDR;
            mem_din_q  <= 32'd0;
            run_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
            rx_ready_q <= rx_ready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            run_q      <= run_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        idx_d      = idx_q;
        word_d     = word_q;
        csum_d     = csum_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;

        hs   = bus.rx_valid && rx_ready_q;
        sync = hs && (bus.rx_data == SYNC_BYTE);

        case (state_q)
            // IDLE, RUN and ERR all restart a frame on the sync byte; anything else is dropped.
            S_IDLE, S_RUN, S_ERR: begin
                if (sync) begin
                    state_d = S_LEN;
                    cnt_d   = 2'd0;
                    idx_d   = 32'd0;
                    csum_d  = 8'd0;
                end
            end
            S_LEN: begin
                if (hs) begin
                    len_d[{cnt_q, 3'b000} +: 8] = bus.rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (len_d > 32'(MAX_WORDS)) begin
                            state_d = S_ERR;
                        end else if (len_d == 32'd0) begin
                            state_d = S_CSUM;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (hs) begin
                    word_d[{cnt_q, 3'b000} +: 8] = bus.rx_data;
                    csum_d = csum_q ^ bus.rx_data;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // Address and data are loaded here so they are valid together with mem_we.
                        state_d    = S_WRITE;
                        mem_din_d  = word_d;
                        mem_addr_d = BASE_ADDR + (idx_q << 2);
                    end
                end
            end
            S_WRITE: begin
                idx_d   = idx_q + 32'd1;
                state_d = (idx_q + 32'd1 == len_q) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (hs) begin
                    state_d = (bus.rx_data == csum_q) ? S_RUN : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so every one of them is a flop.
        rx_ready_d = (state_d != S_WRITE);
        mem_we_d   = (state_d == S_WRITE) ? 4'hF : 4'h0;
        run_d      = (state_d == S_RUN);
        err_d      = (state_d == S_ERR);
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign cpu_rst_n_o  = run_q;
    assign done_o       = run_q;
    assign err_o        = err_q;

endmodule
